// File: rtl/nand_reduce_pipe.sv
// Multi-lane AND/NAND reduction built from a 3-input AND tree. Each tree level
// is one register rank, and the ranks pass beats along with valid/ready.
module nand_reduce_pipe #(
  parameter int NIN   = 9,
  parameter int WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH*NIN-1:0] A,
  input  logic                 INV,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [WIDTH-1:0]     ZN,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY
);

  function automatic int nodes_at(input int n, input int k);
    int c;
    c = n;
    for (int i = 0; i < k; i++) c = (c + 2) / 3;
    return c;
  endfunction

  function automatic int calc_stages(input int n);
    int c;
    int s;
    c = n;
    s = 0;
    while (c > 1) begin
      c = (c + 2) / 3;
      s++;
    end
    return s;
  endfunction

  localparam int STAGES = calc_stages(NIN);

  for (genvar k = 1; k <= STAGES; k++) begin : g_stg
    localparam int NI = nodes_at(NIN, k - 1);
    localparam int NO = nodes_at(NIN, k);

    logic [WIDTH*NI-1:0]   d_in;
    logic [WIDTH*3*NO-1:0] d_pad;
    logic [WIDTH*NO-1:0]   d_red;
    logic [WIDTH*NO-1:0]   q;
    logic                  v_in;
    logic                  inv_in;
    logic                  rdy_dn;
    logic                  v;
    logic                  inv_q;
    logic                  rdy;

    if (k == 1) begin : g_first
      assign d_in   = A;
      assign v_in   = IN_VALID;
      assign inv_in = INV;
    end else begin : g_chain
      assign d_in   = g_stg[k-1].q;
      assign v_in   = g_stg[k-1].v;
      assign inv_in = g_stg[k-1].inv_q;
    end

    if (k == STAGES) begin : g_last
      assign rdy_dn = OUT_READY;
    end else begin : g_inner
      assign rdy_dn = g_stg[k+1].rdy;
    end

    // Each lane's children are padded up to a multiple of 3 with ones, so the
    // partial group at the top of a lane still reduces to a plain AND.
    always_comb begin
      d_pad = '1;
      d_red = '0;
      for (int l = 0; l < WIDTH; l++) begin
        d_pad[l*3*NO +: NI] = d_in[l*NI +: NI];
      end
      for (int l = 0; l < WIDTH; l++) begin
        for (int n = 0; n < NO; n++) begin
          d_red[l*NO + n] = &d_pad[l*3*NO + 3*n +: 3];
        end
      end
    end

    assign rdy = !v || rdy_dn;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        v     <= 1'b0;
        inv_q <= 1'b0;
        q     <= '0;
      end else if (rdy) begin
        v     <= v_in;
        inv_q <= inv_in;
        q     <= d_red;
      end
    end
  end

  assign IN_READY  = g_stg[1].rdy;
  assign OUT_VALID = g_stg[STAGES].v;
  assign ZN        = g_stg[STAGES].inv_q ? ~g_stg[STAGES].q : g_stg[STAGES].q;

endmodule

// File: doc/nand_reduce_pipe.md
Name: nand_reduce_pipe

Overview:
- Parametrised, pipelined, multi-lane NAND/AND reduction for the mcu7t5v0 library.
- Each of WIDTH lanes reduces NIN inputs through a tree of 3-input AND stages, one register rank per tree level.
- The result is optionally inverted, so the block acts as NAND or AND.
- Elastic valid/ready pipeline for datapath wide-compare and all-ones/zero-detect logic, replacing chains of fixed nand3 cells.

Parameters:
NIN, 9, inputs reduced per lane (>=2)
WIDTH, 4, number of independent lanes (>=1)
STAGES, derived = ceil(log3(NIN)), pipeline depth; 2 for NIN=9, 3 for NIN=10..27; not user-overridable

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  asynchronous active-high reset
A  input  WIDTH*NIN  lane l, input j at bit l*NIN+j
INV  input  1  1 = NAND result, 0 = AND result; travels with its beat
IN_VALID  input  1  beat on A/INV valid
IN_READY  output  1  block accepts beat this cycle
ZN  output  WIDTH  reduction result, bit l for lane l
OUT_VALID  output  1  ZN valid
OUT_READY  input  1  consumer accepts ZN this cycle

Behaviour:
- Reset: clock and reset are fixed as CLK, asynchronous, active-high RST.
  - While RST=1 all stage valid bits, data registers and INV copies clear immediately, not on the next edge.
  - Outputs during reset: OUT_VALID=0, ZN=0, IN_READY=1.
  - Reset asserted mid-operation discards all in-flight beats with no partial output.
  - First acceptance is on the first rising edge after RST deasserts.
- Tree:
  - Stage k (1..STAGES) holds per lane ceil(NIN/3^k) partial ANDs.
  - Each node ANDs up to 3 children from stage k-1 (stage 0 = A).
  - Missing children at the top of a group are padded with 1, so padding never changes the result.
  - The last stage holds 1 node per lane.
- Output: ZN[l] = INV_s ? ~node[l] : node[l], where INV_s is the INV captured with that beat. ZN is derived combinationally from the last-stage register, so no extra cycle.
- Handshake per stage k:
  - ready_k = !valid_k || ready_(k+1), with ready_(STAGES+1) = OUT_READY.
  - IN_READY = ready_1. It may depend combinationally on OUT_READY, but never on IN_VALID.
  - Stage k loads from stage k-1 when ready_k. Its new valid_k = valid_(k-1), with valid_0 = IN_VALID.
  - When !ready_k, stage k holds its data, INV and valid.
  - A transfer occurs when IN_VALID && IN_READY at input and OUT_VALID && OUT_READY at output.
- Latency and throughput:
  - A beat accepted on edge n appears with OUT_VALID=1 after edge n+STAGES-1 (visible in cycle n+STAGES) when unstalled.
  - Throughput is 1 beat/cycle.
- Stall: OUT_READY=0 holds ZN/OUT_VALID stable. Bubbles collapse: up to STAGES beats are buffered before IN_READY falls.
- Simultaneous accept and emit in one cycle is legal at full occupancy when OUT_READY=1.
- Ordering: beats leave in acceptance order; none dropped or duplicated.
- IN_VALID with X on A is allowed when IN_VALID=0. Data registers may load any value when the incoming valid is 0.

Test Plan (NIN=9, WIDTH=4 unless stated):
1. Reset: RST=1 mid-stream with 2 beats in flight -> same cycle OUT_VALID=0, ZN=4'h0, IN_READY=1. After release, no stale beat emerges.
2. Lanes: A lane0 = 9'h1FF, lanes1-3 = 9'h1FE, INV=1, OUT_READY=1 -> exactly 2 cycles later OUT_VALID=1, ZN=4'b1110. Same A with INV=0 -> ZN=4'b0001.
3. Group edge: all ones except lane2 bit8 = 0, INV=0 -> ZN=4'b1011. Repeat at NIN=10 with lane2 bit9 = 0 -> ZN[2]=0 after 3 cycles (padding path, STAGES=3).
4. Streaming: 3 back-to-back beats INV=1,0,1, all A ones, OUT_READY=1 -> ZN = 0000, 1111, 0000 on consecutive cycles 2,3,4 after first accept.
5. Backpressure:
   - Stream 5 beats; OUT_READY=0 from cycle 2 for 4 cycles -> IN_READY=0 once 2 beats are buffered; ZN stays constant while stalled.
   - After release all 5 beats arrive in order, none lost or duplicated.
6. Random: random A/INV/IN_VALID/OUT_READY over 10k cycles -> scoreboard match against ~&/&-per-lane reference model. Assertion: ZN and OUT_VALID stable whenever OUT_VALID && !OUT_READY.
